mips_test_sequencer: RTL and testbench

- Synthesizable bring-up sequencer for the MIPS32 pipeline.
- Runs one test in order: initialise the register bank to R[k]=k, stream a program into instruction memory, reset the CPU control state, run for a bounded number of cycles, then dump selected registers over a valid/ready port.
- Sits beside the pipeline top as its debug/load master, so a bring-up run needs no hierarchical pokes.

---
 rtl/mips_test_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_mips_test_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_test_sequencer.sv
// Bring-up sequencer for the MIPS32 pipeline: init register bank, load program, run, dump registers.
// Optional RUN cycle counter on o_cycle_count enabled by defining SEQ_CYCLE_COUNT_EN.
`timescale 1ns/1ps
module mips_test_sequencer #(
  parameter  int DATA_W     = 32,
  parameter  int NUM_REGS   = 32,
  parameter  int PROG_DEPTH = 16,
  parameter  int RUN_CYCLES = 40,
  parameter  int DUMP_FIRST = 0,
  parameter  int DUMP_COUNT = 3,
  localparam int RIDX_W     = $clog2(NUM_REGS),
  localparam int PA_W       = $clog2(PROG_DEPTH),
  localparam int CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_prog_valid,
  output logic              o_prog_ready,
  input  logic [DATA_W-1:0] i_prog_data,
  input  logic              i_prog_last,
  output logic              o_imem_we,
  output logic [PA_W-1:0]   o_imem_addr,
  output logic [DATA_W-1:0] o_imem_wdata,
  output logic              o_rf_we,
  output logic [RIDX_W-1:0] o_rf_waddr,
  output logic [DATA_W-1:0] o_rf_wdata,
  output logic [RIDX_W-1:0] o_rf_raddr,
  input  logic [DATA_W-1:0] i_rf_rdata,
  output logic              o_cpu_init,
  output logic              o_cpu_run,
  input  logic              i_cpu_halted,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [RIDX_W-1:0] o_dump_idx,
  output logic [DATA_W-1:0] o_dump_data,
  output logic [PA_W:0]     o_prog_words,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout,
  output logic [CNT_W-1:0]  o_cycle_count
);

  localparam int DLAST = (DUMP_COUNT > 0) ? DUMP_COUNT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOAD, S_CINIT, S_RUN, S_DRD, S_DWAIT, S_DONE
  } state_t;

  state_t              r_state;
  logic                r_prog_ready, r_imem_we, r_rf_we, r_cpu_init, r_cpu_run;
  logic                r_dump_valid, r_busy, r_done, r_timeout;
  logic [PA_W-1:0]     r_imem_addr;
  logic [DATA_W-1:0]   r_imem_wdata, r_rf_wdata;
  logic [RIDX_W-1:0]   r_rf_waddr, r_rf_raddr, r_dump_idx;
  logic [PA_W:0]       r_prog_words;
  logic [CNT_W-1:0]    r_run_cnt;
  logic [RIDX_W:0]     r_di;
  logic                w_start_ok;

  assign w_start_ok = i_start && (r_state == S_IDLE || r_state == S_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_prog_ready <= 1'b0;
      r_imem_we    <= 1'b0;
      r_imem_addr  <= '0;
      r_imem_wdata <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_rf_raddr   <= '0;
      r_cpu_init   <= 1'b0;
      r_cpu_run    <= 1'b0;
      r_dump_valid <= 1'b0;
      r_dump_idx   <= '0;
      r_prog_words <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
      r_run_cnt    <= '0;
      r_di         <= '0;
    end else begin
      r_imem_we  <= 1'b0;
      r_cpu_init <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: if (w_start_ok) begin
          r_state      <= S_INIT;
          r_busy       <= 1'b1;
          r_done       <= 1'b0;
          r_rf_we      <= 1'b1;
          r_rf_waddr   <= '0;
          r_rf_wdata   <= '0;
          r_prog_words <= '0;
          r_timeout    <= 1'b0;
        end
        S_INIT: begin
          if (r_rf_waddr == RIDX_W'(NUM_REGS - 1)) begin
            r_rf_we      <= 1'b0;
            r_prog_ready <= 1'b1;
            r_state      <= S_LOAD;
          end else begin
            r_rf_waddr <= r_rf_waddr + 1'b1;
            r_rf_wdata <= DATA_W'(r_rf_waddr + 1'b1);
          end
        end
        S_LOAD: if (i_prog_valid && r_prog_ready) begin
          r_imem_we    <= 1'b1;
          r_imem_addr  <= r_prog_words[PA_W-1:0];
          r_imem_wdata <= i_prog_data;
          r_prog_words <= r_prog_words + 1'b1;
          // Ready is registered, so it must drop on the edge of the final accepted beat.
          if (i_prog_last || r_prog_words == (PA_W+1)'(PROG_DEPTH - 1)) begin
            r_prog_ready <= 1'b0;
            r_cpu_init   <= 1'b1;
            r_state      <= S_CINIT;
          end
        end
        S_CINIT: begin
          r_cpu_run <= 1'b1;
          r_run_cnt <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          r_run_cnt <= r_run_cnt + 1'b1;
          if (i_cpu_halted || r_run_cnt == CNT_W'(RUN_CYCLES - 1)) begin
            r_cpu_run  <= 1'b0;
            r_timeout  <= !i_cpu_halted;
            r_rf_raddr <= RIDX_W'(DUMP_FIRST);
            r_di       <= '0;
            if (DUMP_COUNT == 0) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_DRD;
            end
          end
        end
        S_DRD: begin
          r_dump_valid <= 1'b1;
          r_dump_idx   <= r_rf_raddr;
          r_state      <= S_DWAIT;
        end
        S_DWAIT: if (i_dump_ready) begin
          r_dump_valid <= 1'b0;
          if (r_di == (RIDX_W+1)'(DLAST)) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_di       <= r_di + 1'b1;
            r_rf_raddr <= r_rf_raddr + 1'b1;
            r_state    <= S_DRD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [CNT_W-1:0] r_cyc;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                             r_cyc <= '0;
    else if (w_start_ok)                      r_cyc <= '0;
    else if (r_state == S_RUN && r_cyc != '1) r_cyc <= r_cyc + 1'b1;
  end
  assign o_cycle_count = r_cyc;
`else
  assign o_cycle_count = '0;
`endif

  // Read address is held through the wait state, so the registered read data stays stable.
  assign o_dump_data  = r_dump_valid ? i_rf_rdata : '0;
  assign o_prog_ready = r_prog_ready;
  assign o_imem_we    = r_imem_we;
  assign o_imem_addr  = r_imem_addr;
  assign o_imem_wdata = r_imem_wdata;
  assign o_rf_we      = r_rf_we;
  assign o_rf_waddr   = r_rf_waddr;
  assign o_rf_wdata   = r_rf_wdata;
  assign o_rf_raddr   = r_rf_raddr;
  assign o_cpu_init   = r_cpu_init;
  assign o_cpu_run    = r_cpu_run;
  assign o_dump_valid = r_dump_valid;
  assign o_dump_idx   = r_dump_idx;
  assign o_prog_words = r_prog_words;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_mips_test_sequencer.sv
// Directed bench for mips_test_sequencer: register-bank and CPU models, dump scoreboard.
`timescale 1ns/1ps
module tb_mips_test_sequencer;
  logic        clk = 0, rst_n = 0, start = 0, prog_valid = 0, prog_last = 0, dump_ready = 1;
  logic [31:0] prog_data = '0, rf_rdata, imem_wdata, rf_wdata, dump_data;
  logic        cpu_halted, prog_ready, imem_we, rf_we, cpu_init, cpu_run, dump_valid;
  logic        busy, done, timeout;
  logic [3:0]  imem_addr;
  logic [4:0]  rf_waddr, rf_raddr, dump_idx;
  logic [4:0]  prog_words;
  logic [15:0] cycle_count;

`ifdef SEQ_CYCLE_COUNT_EN
  localparam bit CC = 1'b1;
`else
  localparam bit CC = 1'b0;
`endif

  always #5 clk = ~clk;

  mips_test_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
    .i_prog_valid(prog_valid), .o_prog_ready(prog_ready), .i_prog_data(prog_data), .i_prog_last(prog_last),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_rf_raddr(rf_raddr), .i_rf_rdata(rf_rdata),
    .o_cpu_init(cpu_init), .o_cpu_run(cpu_run), .i_cpu_halted(cpu_halted),
    .o_dump_valid(dump_valid), .i_dump_ready(dump_ready), .o_dump_idx(dump_idx), .o_dump_data(dump_data),
    .o_prog_words(prog_words), .o_busy(busy), .o_done(done), .o_timeout(timeout),
    .o_cycle_count(cycle_count)
  );

  int errors = 0, checks = 0;
  int rf_exp_k, rf_wr_cnt, run_len, dump_cnt, bp_cnt, halt_at = -1;
  bit stall_prev = 0;
  logic [4:0]  hold_idx;
  logic [31:0] hold_data;
  logic [31:0] rf [32];
  logic [35:0] imem_q [$];
  logic [36:0] sb [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pword(input int i);
    return 32'h0001_1000 * 32'(i + 1);
  endfunction

  // Register bank with registered read port, and a CPU that halts on a chosen RUN cycle.
  always @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    rf_rdata <= rf[rf_raddr];
  end
  assign cpu_halted = cpu_run && (halt_at >= 0) && (run_len == halt_at + 1);

  always @(negedge clk) begin
    logic [36:0] e;
    if (rf_we) begin
      chk("rf_wdata", rf_wdata, {27'b0, rf_waddr});
      chk("rf_order", rf_waddr, rf_exp_k);
      rf_exp_k++;
      rf_wr_cnt++;
    end
    if (imem_we) imem_q.push_back({imem_addr, imem_wdata});
    if (cpu_run) run_len++;
    if (dump_valid) begin
      if (stall_prev) begin
        chk("dump_hold_idx", dump_idx, hold_idx);
        chk("dump_hold_data", dump_data, hold_data);
      end
      if (dump_ready) begin
        if (sb.size() == 0) chk("dump_extra", 1, 0);
        else begin
          e = sb.pop_front();
          chk("dump_idx", dump_idx, e[36:32]);
          chk("dump_data", dump_data, e[31:0]);
        end
        dump_cnt++;
        stall_prev = 0;
      end else begin
        stall_prev = 1;
        hold_idx   = dump_idx;
        hold_data  = dump_data;
        bp_cnt++;
      end
    end else begin
      if (stall_prev) chk("dump_hold_valid", 0, 1);
      stall_prev = 0;
    end
  end

  task automatic chk_zero(input string t);
    chk({t, "_ctl"}, {busy, done, prog_ready, imem_we, rf_we, cpu_init, cpu_run, dump_valid, timeout}, 0);
    chk({t, "_cnt"}, {prog_words, cycle_count}, 0);
    chk({t, "_addr"}, {imem_addr, rf_waddr, rf_raddr, dump_idx}, 0);
    chk({t, "_wdata"}, {imem_wdata, rf_wdata}, 0);
    chk({t, "_ddata"}, dump_data, 0);
  endtask

  task automatic pulse_start();
    start = 1; @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_ready(input string t);
    bit ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = prog_ready; end
    chk({t, "_ready"}, ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, output bit ok);
    prog_valid = 1; prog_data = d; prog_last = last; ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = prog_ready; end
    @(posedge clk); #1 prog_valid = 0; prog_last = 0;
  endtask

  // Called at posedge+1; ends at posedge+1.
  task automatic run(input string t, input int nw, input bit use_last, input int h_at,
                     input bit mid_start, input bit bp, input int exp_run, input bit exp_to);
    bit ok;
    int sent, exp_words;
    exp_words = (nw > 16) ? 16 : nw;
    halt_at = h_at; rf_exp_k = 0; rf_wr_cnt = 0; run_len = 0; dump_cnt = 0; bp_cnt = 0;
    imem_q.delete(); sb.delete();
    for (int j = 0; j < 3; j++) sb.push_back({5'(j), 32'(j)});
    pulse_start();
    wait_ready(t);
    chk({t, "_rfwr_init"}, rf_wr_cnt, 32);
    if (use_last) begin
      for (int w = 0; w < nw; w++) begin
        send(pword(w), w == nw - 1, ok);
        chk({t, "_send"}, ok, 1);
      end
    end else begin
      sent = 0; prog_valid = 1; prog_data = pword(0);
      for (int c = 0; c < 30; c++) begin
        @(negedge clk); if (prog_valid && prog_ready) sent++;
        @(posedge clk); #1 prog_data = pword(sent);
        if (sent >= nw) prog_valid = 0;
      end
      prog_valid = 0;
      chk({t, "_accepted"}, sent, 16);
      chk({t, "_ready_low"}, prog_ready, 0);
    end
    if (mid_start) begin
      ok = 0;
      for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = (run_len >= 3); end
      chk({t, "_reach_run"}, ok, 1);
      @(posedge clk); #1 pulse_start();
    end
    if (bp) begin
      ok = 0;
      for (int c = 0; c < 300 && !ok; c++) begin @(negedge clk); ok = dump_valid && dump_idx == 0; end
      @(posedge clk); #1 dump_ready = 0;
      for (int c = 0; c < 20 && ok; c++) begin @(negedge clk); if (dump_valid && dump_idx == 1) break; end
      repeat (4) @(negedge clk);
      @(posedge clk); #1 dump_ready = 1;
      chk({t, "_bp_seen"}, ok, 1);
    end
    ok = 0;
    for (int c = 0; c < 500 && !ok; c++) begin @(negedge clk); ok = done; end
    chk({t, "_done"}, ok, 1);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_cpu_run"}, cpu_run, 0);
    chk({t, "_words"}, prog_words, exp_words);
    chk({t, "_timeout"}, timeout, exp_to);
    chk({t, "_run_len"}, run_len, exp_run);
    chk({t, "_cycles"}, cycle_count, CC ? exp_run : 0);
    chk({t, "_dumps"}, dump_cnt, 3);
    chk({t, "_sb_empty"}, sb.size(), 0);
    chk({t, "_stalls"}, bp_cnt, bp ? 5 : 0);
    chk({t, "_rfwr"}, rf_wr_cnt, 32);
    chk({t, "_r5"}, rf[5], 5);
    chk({t, "_r31"}, rf[31], 31);
    chk({t, "_imem_n"}, imem_q.size(), exp_words);
    for (int i = 0; i < imem_q.size(); i++)
      chk({t, "_imem"}, imem_q[i], {4'(i), pword(i)});
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;
    run("basic",  1, 1, -1, 0, 0, 40, 1);
    run("halt",   1, 1,  7, 1, 0,  8, 0);
    run("ovf",   20, 0, -1, 0, 0, 40, 1);
    run("bp",     2, 1,  5, 0, 1,  6, 0);

    // Abandon a test part-way through the program load.
    rf_exp_k = 0; rf_wr_cnt = 0; imem_q.delete();
    pulse_start();
    wait_ready("midrst");
    for (int w = 0; w < 3; w++) begin send(pword(w), 1'b0, ok); chk("midrst_send", ok, 1); end
    @(negedge clk); #2 rst_n = 0;
    #1 chk_zero("midrst");
    chk("midrst_imem", imem_q.size(), 3);
    repeat (2) @(posedge clk); #1 rst_n = 1;
    repeat (5) @(negedge clk);
    chk("midrst_nowr_imem", imem_q.size(), 3);
    chk("midrst_nowr_rf", rf_wr_cnt, 32);
    chk("midrst_idle", {busy, done}, 0);
    @(posedge clk); #1;
    run("restart", 1, 1, -1, 0, 0, 40, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
